note_char_seq: RTL and testbench

//  Multi-channel successor to the single-note glyph decoder. Watches NUM_CH note codes,

---
 rtl/note_char_seq_pkg.sv | 54 +++++
 rtl/note_char_seq_div12.sv | 64 ++++++
 rtl/note_char_seq.sv | 198 +++++++++++++++++++
 tb/tb_note_char_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_char_seq_pkg.sv
// Shared definitions for the multi-channel note glyph sequencer.
//   - glyph codes (6-bit character-ROM indices before the row shift)
//   - FSM state encoding, beat position encodings
//   - semitone -> (letter, sharp) mapping helper
package note_char_seq_pkg;

    localparam int SEMITONES = 12;

    // Highest divide-by-12 quotient that still gives a printable octave (8 -> octave 9).
    localparam int MAX_QUOT = 8;

    localparam logic [5:0] GLYPH_SPACE   = 6'h20;
    localparam logic [5:0] GLYPH_SHARP   = 6'h23;
    localparam logic [5:0] GLYPH_DIGIT0  = 6'h30;
    localparam logic [5:0] GLYPH_INVALID = 6'h18;

    localparam logic [1:0] POS_LETTER = 2'd0;
    localparam logic [1:0] POS_ACC    = 2'd1;
    localparam logic [1:0] POS_OCT    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // letter: glyph code A..G = 1..7
    typedef struct packed {
        logic [2:0] letter;
        logic       sharp;
    } semi_map_t;

    function automatic semi_map_t semi_map(input logic [3:0] s);
        semi_map_t m;
        m = '{letter: 3'd1, sharp: 1'b0};
        case (s)
            4'd0:    m = '{letter: 3'd1, sharp: 1'b0};  // A
            4'd1:    m = '{letter: 3'd1, sharp: 1'b1};  // A#
            4'd2:    m = '{letter: 3'd2, sharp: 1'b0};  // B
            4'd3:    m = '{letter: 3'd3, sharp: 1'b0};  // C
            4'd4:    m = '{letter: 3'd3, sharp: 1'b1};  // C#
            4'd5:    m = '{letter: 3'd4, sharp: 1'b0};  // D
            4'd6:    m = '{letter: 3'd4, sharp: 1'b1};  // D#
            4'd7:    m = '{letter: 3'd5, sharp: 1'b0};  // E
            4'd8:    m = '{letter: 3'd6, sharp: 1'b0};  // F
            4'd9:    m = '{letter: 3'd6, sharp: 1'b1};  // F#
            4'd10:   m = '{letter: 3'd7, sharp: 1'b0};  // G
            4'd11:   m = '{letter: 3'd7, sharp: 1'b1};  // G#
            default: m = '{letter: 3'd1, sharp: 1'b0};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/note_char_seq_div12.sv
// Iterative divide-by-12: k -> {quotient, remainder}, one subtraction per cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start_i      load k_i and begin dividing (ignored result of any run in flight)
//   k_i          dividend (note code minus one)
//   done_o       1 for exactly one cycle, when the remainder has dropped below 12;
//                quot_o/rem_o are final in that cycle and hold until the next start
//   quot_o       quotient (octave - 1)
//   rem_o        remainder (semitone 0..11)
// Cycles from start to done (inclusive of the done cycle) = k/12 + 1.
module note_char_seq_div12
    import note_char_seq_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] k_i,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic [3:0]   rem_o
);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quot_q, quot_d;
    logic         run_q, run_d;

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        run_d  = run_q;
        done_o = 1'b0;
        if (start_i) begin
            rem_d  = k_i;
            quot_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (int'(rem_q) >= SEMITONES) begin
                rem_d  = rem_q - W'(SEMITONES);
                quot_d = quot_q + W'(1);
            end else begin
                done_o = 1'b1;
                run_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            run_q  <= run_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q[3:0];

endmodule

// File: rtl/note_char_seq.sv
// Multi-channel note glyph sequencer. Watches NUM_CH note codes, marks channels whose
// code changed (or all channels on refresh) dirty, and for each dirty channel streams
// three glyph addresses: letter, accidental, octave digit.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   notes_in       packed note codes, channel c at [c*NOTE_W +: NOTE_W]; 0 = rest
//   refresh        one-cycle pulse, marks every channel dirty
//   char_ready     sink accepts the current beat
//   char_valid     beat valid
//   char_ch        channel of the beat
//   char_pos       0 letter, 1 accidental, 2 octave digit
//   char_addr      glyph code << GLYPH_SHIFT (0 when no beat is valid)
//   busy           FSM not idle or any channel dirty
//   dbg_state_o    current FSM state (state_e encoding)
// Handshake: a beat transfers on a rising edge where char_valid && char_ready. While
// char_valid is high and char_ready low, char_ch/char_pos/char_addr hold. char_valid
// never drops without a transfer except on reset.
module note_char_seq
    import note_char_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NOTE_W      = 6,
    parameter int GLYPH_SHIFT = 3,
    parameter int ADDR_W      = 9,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*NOTE_W-1:0] notes_in,
    input  logic                     refresh,
    input  logic                     char_ready,
    output logic                     char_valid,
    output logic [CH_W-1:0]          char_ch,
    output logic [1:0]               char_pos,
    output logic [ADDR_W-1:0]        char_addr,
    output logic                     busy,
    output logic [1:0]               dbg_state_o
);

    state_e                   state_q, state_d;
    logic [NUM_CH*NOTE_W-1:0] prev_q;
    logic [NUM_CH-1:0]        dirty_q, dirty_d;
    logic [CH_W-1:0]          last_ch_q, last_ch_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [1:0]               pos_q, pos_d;
    logic                     rest_q, rest_d;

    logic [NUM_CH-1:0]        changed;
    logic [NUM_CH-1:0]        clr_mask;
    logic                     pick_found;
    logic [CH_W-1:0]          pick_ch;
    logic [CH_W-1:0]          scan_idx;
    logic [NOTE_W-1:0]        sel_note;

    logic                     div_start;
    logic [NOTE_W-1:0]        div_k;
    logic                     div_done;
    logic [NOTE_W-1:0]        div_quot;
    logic [3:0]               div_rem;

    semi_map_t                sm;
    logic                     oct_bad;
    logic [3:0]               oct_digit;
    logic [5:0]               glyph;
    logic [ADDR_W-1:0]        addr_full;

    note_char_seq_div12 #(.W(NOTE_W)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .k_i     (div_k),
        .done_o  (div_done),
        .quot_o  (div_quot),
        .rem_o   (div_rem)
    );

    // Per-channel change detect against last cycle's sample.
    always_comb begin
        changed = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            changed[c] = (notes_in[c*NOTE_W +: NOTE_W] != prev_q[c*NOTE_W +: NOTE_W]);
        end
    end

    // Round robin: first dirty channel strictly after last_ch, wrapping; last_ch itself
    // is scanned last so a channel that keeps changing cannot starve the others.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        scan_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_idx = CH_W'((int'(last_ch_q) + i) % NUM_CH);
            if (!pick_found && dirty_q[scan_idx]) begin
                pick_found = 1'b1;
                pick_ch    = scan_idx;
            end
        end
    end

    assign sel_note = notes_in[int'(pick_ch)*NOTE_W +: NOTE_W];

    always_comb begin
        state_d    = state_q;
        last_ch_d  = last_ch_q;
        ch_d       = ch_q;
        pos_d      = pos_q;
        rest_d     = rest_q;
        clr_mask   = '0;
        div_start  = 1'b0;
        div_k      = '0;
        char_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    ch_d              = pick_ch;
                    last_ch_d         = pick_ch;
                    clr_mask[pick_ch] = 1'b1;
                    pos_d             = POS_LETTER;
                    if (sel_note == '0) begin
                        rest_d  = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        rest_d    = 1'b0;
                        div_start = 1'b1;
                        div_k     = sel_note - NOTE_W'(1);
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                char_valid = 1'b1;
                if (char_ready) begin
                    if (pos_q == POS_OCT) begin
                        pos_d   = POS_LETTER;
                        state_d = ST_IDLE;
                    end else begin
                        pos_d = pos_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Set wins over clear: a change on the channel being captured keeps it dirty.
        dirty_d = (dirty_q & ~clr_mask) | changed | {NUM_CH{refresh}};
    end

    // Glyph mux over the latched divider result.
    always_comb begin
        sm        = semi_map(div_rem);
        oct_bad   = (int'(div_quot) > MAX_QUOT);
        oct_digit = div_quot[3:0] + 4'd1;
        glyph     = GLYPH_SPACE;
        if (rest_q) begin
            glyph = GLYPH_SPACE;
        end else if (oct_bad) begin
            glyph = GLYPH_INVALID;
        end else begin
            case (pos_q)
                POS_LETTER: glyph = {3'b000, sm.letter};
                POS_ACC:    glyph = sm.sharp ? GLYPH_SHARP : GLYPH_SPACE;
                default:    glyph = GLYPH_DIGIT0 + {2'b00, oct_digit};
            endcase
        end
        addr_full = {{(ADDR_W-6){1'b0}}, glyph} << GLYPH_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            dirty_q   <= '1;
            last_ch_q <= CH_W'(NUM_CH - 1);
            ch_q      <= '0;
            pos_q     <= POS_LETTER;
            rest_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= notes_in;
            dirty_q   <= dirty_d;
            last_ch_q <= last_ch_d;
            ch_q      <= ch_d;
            pos_q     <= pos_d;
            rest_q    <= rest_d;
        end
    end

    assign char_ch     = ch_q;
    assign char_pos    = pos_q;
    assign char_addr   = char_valid ? addr_full : '0;
    assign busy        = (state_q != ST_IDLE) || (|dirty_q);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_note_char_seq.sv
// Bench for note_char_seq: a 4-channel NOTE_W=6 instance (main) and a 1-channel
// NOTE_W=7 instance (high octaves). Expected beats are hand-computed constants pushed
// into queues at stimulus time; monitors pop and compare on every accepted beat.
module tb_note_char_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] notes;
    logic        refresh;
    logic        char_ready;
    logic        char_valid;
    logic [1:0]  char_ch;
    logic [1:0]  char_pos;
    logic [8:0]  char_addr;
    logic        busy;
    logic [1:0]  dbg_state;

    logic        rst2_n;
    logic [6:0]  note2;
    logic        refresh2;
    logic        ready2;
    logic        valid2;
    logic [0:0]  ch2;
    logic [1:0]  pos2;
    logic [8:0]  addr2;
    logic        busy2;
    logic [1:0]  dbg2;

    note_char_seq #(.NUM_CH(4), .NOTE_W(6), .GLYPH_SHIFT(3), .ADDR_W(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .notes_in    (notes),
        .refresh     (refresh),
        .char_ready  (char_ready),
        .char_valid  (char_valid),
        .char_ch     (char_ch),
        .char_pos    (char_pos),
        .char_addr   (char_addr),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    note_char_seq #(.NUM_CH(1), .NOTE_W(7), .GLYPH_SHIFT(3), .ADDR_W(9)) dut2 (
        .clk         (clk),
        .rst_n       (rst2_n),
        .notes_in    (note2),
        .refresh     (refresh2),
        .char_ready  (ready2),
        .char_valid  (valid2),
        .char_ch     (ch2),
        .char_pos    (pos2),
        .char_addr   (addr2),
        .busy        (busy2),
        .dbg_state_o (dbg2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] exp_q[$];
    logic [12:0] exp2_q[$];
    logic [12:0] mon_got, mon_exp, mon2_got, mon2_exp;

    always @(negedge clk) begin
        if (rst_n && char_valid && char_ready) begin
            mon_got = {char_ch, char_pos, char_addr};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got ch%0d pos%0d addr 0x%03h, required no beat",
                         char_ch, char_pos, char_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL beat: got ch%0d pos%0d addr 0x%03h, required ch%0d pos%0d addr 0x%03h",
                             mon_got[12:11], mon_got[10:9], mon_got[8:0],
                             mon_exp[12:11], mon_exp[10:9], mon_exp[8:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst2_n && valid2 && ready2) begin
            mon2_got = {1'b0, ch2, pos2, addr2};
            n_checks++;
            if (exp2_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat2_unexpected: got pos%0d addr 0x%03h, required no beat", pos2, addr2);
            end else begin
                mon2_exp = exp2_q.pop_front();
                if (mon2_got !== mon2_exp) begin
                    n_fail++;
                    $display("FAIL beat2: got ch%0d pos%0d addr 0x%03h, required ch%0d pos%0d addr 0x%03h",
                             mon2_got[11], mon2_got[10:9], mon2_got[8:0],
                             mon2_exp[11], mon2_exp[10:9], mon2_exp[8:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push3(input logic [1:0] ch, input logic [8:0] a0, input logic [8:0] a1,
                         input logic [8:0] a2);
        exp_q.push_back({ch, 2'd0, a0});
        exp_q.push_back({ch, 2'd1, a1});
        exp_q.push_back({ch, 2'd2, a2});
    endtask

    task automatic push_blank4();
        for (int c = 0; c < 4; c++) begin
            push3(c[1:0], 9'h100, 9'h100, 9'h100);
        end
    endtask

    task automatic push2(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2);
        exp2_q.push_back({2'b00, 2'd0, a0});
        exp2_q.push_back({2'b00, 2'd1, a1});
        exp2_q.push_back({2'b00, 2'd2, a2});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (busy && n < 400);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_idle2(input string name);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (busy2 && n < 400);
        check({name, "_idle"}, {31'd0, busy2}, 32'd0);
        check({name, "_drained"}, exp2_q.size(), 32'd0);
    endtask

    task automatic wait_beat(input string name, input logic [1:0] ch, input logic [1:0] pos);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!(char_valid && char_ch == ch && char_pos == pos) && n < 200);
        if (!(char_valid && char_ch == ch && char_pos == pos)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: beat ch%0d pos%0d not seen in %0d cycles, required it", name, ch, pos, n);
        end
    endtask

    // Edges counted from the first edge after the input change until char_valid is seen.
    task automatic measure_latency(input string name, input int req);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!char_valid && n < 60);
        check(name, n, req);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, {31'd0, char_valid}, 32'd0);
        check({name, "_ch"},    {30'd0, char_ch},    32'd0);
        check({name, "_pos"},   {30'd0, char_pos},   32'd0);
        check({name, "_addr"},  {23'd0, char_addr},  32'd0);
        check({name, "_busy"},  {31'd0, busy},       32'd1);
        check({name, "_state"}, {30'd0, dbg_state},  32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n      = 1'b0;
        rst2_n     = 1'b0;
        notes      = '0;
        note2      = '0;
        refresh    = 1'b0;
        refresh2   = 1'b0;
        char_ready = 1'b1;
        ready2     = 1'b1;
        tick(3);

        // 1: reset values, then blank repaint of every channel
        check_reset_outputs("rst");
        check("rst2_valid", {31'd0, valid2}, 32'd0);
        check("rst2_busy",  {31'd0, busy2},  32'd1);
        check("rst2_state", {30'd0, dbg2},   32'd0);
        push_blank4();
        push2(9'h100, 9'h100, 9'h100);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        wait_idle("t1");
        wait_idle2("t1b");

        // 2: ch2 -> 2 (A#1), ch1 -> 63 (B6) with DIV latency, ch2 -> rest latency
        notes[12 +: 6] = 6'd2;
        push3(2'd2, 9'h008, 9'h118, 9'h188);
        wait_idle("t2a");
        notes[6 +: 6] = 6'd63;
        push3(2'd1, 9'h010, 9'h100, 9'h1B0);
        measure_latency("lat_div6", 8);
        wait_idle("t2b");
        notes[12 +: 6] = 6'd0;
        push3(2'd2, 9'h100, 9'h100, 9'h100);
        measure_latency("lat_rest", 2);
        wait_idle("t2c");

        // 3: stall 5 cycles on pos1 of ch3 note 14 (A#2)
        notes[18 +: 6] = 6'd14;
        push3(2'd3, 9'h008, 9'h118, 9'h190);
        wait_beat("t3", 2'd3, 2'd1);
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_hold", {18'd0, char_valid, char_ch, char_pos, char_addr},
                  {18'd0, 1'b1, 2'd3, 2'd1, 9'h118});
        end
        char_ready = 1'b1;
        wait_idle("t3");

        // 4: make last_ch=0, then ch0/ch3 change together; ch0 changes again mid-emit
        notes[0 +: 6] = 6'd3;
        push3(2'd0, 9'h010, 9'h100, 9'h188);
        wait_idle("t4a");
        notes[0 +: 6]  = 6'd25;
        notes[18 +: 6] = 6'd1;
        push3(2'd3, 9'h008, 9'h100, 9'h188);
        push3(2'd0, 9'h008, 9'h100, 9'h198);
        wait_beat("t4", 2'd0, 2'd0);
        notes[0 +: 6] = 6'd37;
        push3(2'd0, 9'h008, 9'h100, 9'h1A0);
        wait_idle("t4b");

        // refresh: every channel re-emitted, order after last_ch=0 is 1,2,3,0
        push3(2'd1, 9'h010, 9'h100, 9'h1B0);
        push3(2'd2, 9'h100, 9'h100, 9'h100);
        push3(2'd3, 9'h008, 9'h100, 9'h188);
        push3(2'd0, 9'h008, 9'h100, 9'h1A0);
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        wait_idle("t4r");

        // 5: NOTE_W=7 octave boundaries: 121 (oct 11), 109 (oct 10), 97 (oct 9)
        note2 = 7'd121;
        push2(9'h0C0, 9'h0C0, 9'h0C0);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!valid2 && n < 60);
        check("lat_div11", n, 13);
        wait_idle2("t5a");
        note2 = 7'd109;
        push2(9'h0C0, 9'h0C0, 9'h0C0);
        wait_idle2("t5b");
        note2 = 7'd97;
        push2(9'h008, 9'h100, 9'h1C8);
        wait_idle2("t5c");

        // 6a: reset while in DIV (ch1 note 50 -> A#5)
        notes[6 +: 6] = 6'd50;
        push3(2'd1, 9'h008, 9'h118, 9'h1A8);
        tick(3);
        check("t6a_in_div", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        notes = '0;
        tick(1);
        check_reset_outputs("t6a");
        exp_q.delete();
        push_blank4();
        rst_n = 1'b1;
        wait_idle("t6a");

        // 6b: reset while stalled on pos1 (ch2 note 2)
        notes[12 +: 6] = 6'd2;
        push3(2'd2, 9'h008, 9'h118, 9'h188);
        wait_beat("t6b", 2'd2, 2'd1);
        char_ready = 1'b0;
        tick(2);
        rst_n = 1'b0;
        notes = '0;
        tick(1);
        check_reset_outputs("t6b");
        exp_q.delete();
        push_blank4();
        char_ready = 1'b1;
        rst_n      = 1'b1;
        wait_idle("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
